// File: rtl/dna_pkg.sv
// Shared types and constants for the DNA read deserializer slice.
package dna_pkg;

  localparam int NUM_OF_NUCLEOTIDES = 40;
  localparam int ASCII_SIZE         = 8;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LC = 8'h63;
  localparam logic [7:0] ASCII_LG = 8'h67;
  localparam logic [7:0] ASCII_LT = 8'h74;

  typedef enum logic [1:0] {
    NT_A = 2'b00,
    NT_C = 2'b01,
    NT_G = 2'b10,
    NT_T = 2'b11
  } nucleotide_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_COLLECT = 1'b0;
  localparam state_t ST_HOLD    = 1'b1;

endpackage

// File: rtl/nucleotide_decode.sv
// ASCII nucleotide to 2-bit symbol decoder with invalid flag.
// DNA_LOWERCASE_EN: when defined, lowercase a/c/g/t decode like uppercase.
module nucleotide_decode #(
  parameter int ASCII_SIZE = dna_pkg::ASCII_SIZE
) (
  input  logic [ASCII_SIZE-1:0] in_char,
  output dna_pkg::nucleotide_t  sym,
  output logic                  invalid
);
  import dna_pkg::*;

  always_comb begin
    sym     = NT_A;
    invalid = 1'b0;
    case (in_char)
      ASCII_SIZE'(ASCII_A):  sym = NT_A;
      ASCII_SIZE'(ASCII_C):  sym = NT_C;
      ASCII_SIZE'(ASCII_G):  sym = NT_G;
      ASCII_SIZE'(ASCII_T):  sym = NT_T;
`ifdef DNA_LOWERCASE_EN
      ASCII_SIZE'(ASCII_LA): sym = NT_A;
      ASCII_SIZE'(ASCII_LC): sym = NT_C;
      ASCII_SIZE'(ASCII_LG): sym = NT_G;
      ASCII_SIZE'(ASCII_LT): sym = NT_T;
`endif
      // Unknown codes pack as A and poison the frame.
      default:               invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/dna_read_deserializer.sv
// Collects NUM_OF_NUCLEOTIDES ASCII characters into one packed 2-bit frame with
// a sticky error flag; DNA_LOWERCASE_EN is handled inside nucleotide_decode.
module dna_read_deserializer #(
  parameter int NUM_OF_NUCLEOTIDES = dna_pkg::NUM_OF_NUCLEOTIDES,
  parameter int ASCII_SIZE         = dna_pkg::ASCII_SIZE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [ASCII_SIZE-1:0]           in_char,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*NUM_OF_NUCLEOTIDES-1:0] out_bits,
  output logic                            out_err
);
  import dna_pkg::*;

  localparam int W     = 2 * NUM_OF_NUCLEOTIDES;
  localparam int CNT_W = (NUM_OF_NUCLEOTIDES > 1) ? $clog2(NUM_OF_NUCLEOTIDES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OF_NUCLEOTIDES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     pack_p0;
  logic             err_p0;
  nucleotide_t      sym;
  logic             sym_invalid;
  logic             accept;
  logic             last;
  logic [W-1:0]     pack_next;

  nucleotide_decode #(
    .ASCII_SIZE(ASCII_SIZE)
  ) u_decode (
    .in_char (in_char),
    .sym     (sym),
    .invalid (sym_invalid)
  );

  assign in_ready  = (state == ST_COLLECT);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (cnt == CNT_LAST);
  // Shift left so the first nucleotide ends up in the top symbol slot.
  assign pack_next = {pack_p0[W-3:0], sym};

  // Collect stage: counter, packing register, sticky error; hold stage: output frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_COLLECT;
      cnt      <= '0;
      pack_p0  <= '0;
      err_p0   <= 1'b0;
      out_bits <= '0;
      out_err  <= 1'b0;
    end else if (flush) begin
      state   <= ST_COLLECT;
      cnt     <= '0;
      pack_p0 <= '0;
      err_p0  <= 1'b0;
    end else if (state == ST_HOLD) begin
      if (out_ready) state <= ST_COLLECT;
    end else if (accept) begin
      if (last) begin
        cnt      <= '0;
        pack_p0  <= '0;
        err_p0   <= 1'b0;
        out_bits <= pack_next;
        out_err  <= err_p0 | sym_invalid;
        state    <= ST_HOLD;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        pack_p0 <= pack_next;
        err_p0  <= err_p0 | sym_invalid;
      end
    end
  end

endmodule

// File: doc/dna_read_deserializer.md
DNA_READ_DESERIALIZER -- requirements
Module: dna_read_deserializer

Interface
REQ-001 Parameter NUM_OF_NUCLEOTIDES, default 40, is the number of nucleotides per strand frame.
REQ-002 Parameter ASCII_SIZE, default 8, is the width of one nucleotide character.
REQ-003 clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 reset  input  1  is an asynchronous, active-high reset.
REQ-005 flush  input  1  is a synchronous discard of any partial frame.
REQ-006 in_valid  input  1  indicates that a character is offered.
REQ-007 in_char  input  ASCII_SIZE  is the ASCII nucleotide character.
REQ-008 in_ready  output  1  indicates that the block accepts a character this cycle.
REQ-009 out_valid  output  1  indicates that a complete frame is presented.
REQ-010 out_ready  input  1  indicates that the consumer takes the frame.
REQ-011 out_bits  output  2*NUM_OF_NUCLEOTIDES  is the packed 2-bit symbols of the frame.
REQ-012 out_err  output  1  indicates that the frame contained at least one invalid character.

Function
REQ-013 The block SHALL have two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 A character SHALL be accepted only on a cycle with in_valid && in_ready.
REQ-015 The character mapping SHALL be: 'A' (0x41) to 00, 'C' (0x43) to 01, 'G' (0x47) to 10, 'T' (0x54) to 11.
REQ-016 Any other code SHALL pack as 00 and set the frame's sticky error bit.
REQ-017 The first accepted nucleotide SHALL occupy out_bits[2N-1:2N-2], and the last SHALL occupy out_bits[1:0].
REQ-018 The nucleotide counter SHALL count 0..N-1 and have width $clog2(N).
REQ-019 The accept at count N-1 SHALL reset the counter to 0 and move COLLECT to HOLD.
REQ-020 out_valid SHALL assert on the cycle after the Nth accept, giving a latency of 1 cycle.
REQ-021 out_bits and out_err SHALL be registered and held stable while out_valid && !out_ready.
REQ-022 In HOLD, out_ready=1 SHALL move the block to COLLECT on the next cycle.
REQ-023 A new frame's first character SHALL be accepted no earlier than the cycle after the handshake.
REQ-024 The minimum frame period SHALL be N+1 cycles.
REQ-025 The sticky error bit SHALL clear when a new frame begins.
REQ-026 flush=1 in COLLECT SHALL zero the counter, packing register and error bit, and SHALL suppress any same-cycle accept.
REQ-027 flush=1 in HOLD SHALL drop the held frame and return the block to COLLECT.
REQ-028 flush SHALL take priority over out_ready and in_valid.
REQ-029 in_char SHALL be ignored when in_valid=0, and the counter SHALL not advance on such cycles.

Reset
REQ-030 While reset=1, the block SHALL be in COLLECT with counter=0, out_bits=0, out_err=0, out_valid=0 and in_ready=1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame.
REQ-032 After reset deasserts, the first accepted character SHALL be nucleotide 0.

Configuration
REQ-033 With DNA_LOWERCASE_EN defined, 'a' (0x61), 'c' (0x63), 'g' (0x67) and 't' (0x74) SHALL map to the same symbols as their uppercase forms and SHALL not set the error bit.
REQ-034 Without DNA_LOWERCASE_EN, lowercase codes SHALL be treated as invalid characters.

Structure
REQ-035 The shared package dna_pkg SHALL hold NUM_OF_NUCLEOTIDES, ASCII_SIZE, the nucleotide ASCII constants, the nucleotide_t 2-bit enum (A, C, G, T) and the state typedef.
REQ-036 The combinational sub-module nucleotide_decode SHALL convert one character into a 2-bit symbol plus an invalid flag.
REQ-037 The macro DNA_LOWERCASE_EN SHALL be consumed only inside nucleotide_decode.

Verification
REQ-038 Scenario 1: 40 x 'A', consumer always ready -> out_valid 1 cycle after the 40th accept, with out_bits=80'h0 and out_err=0.
REQ-039 Scenario 2: 40 x 'T' with out_ready held low for 5 cycles -> out_bits=all-ones held stable for 5 cycles with in_ready=0, then COLLECT resumes.
REQ-040 Scenario 3: the sequence "ACGT" repeated 10 times -> out_bits equals the 8'h1B byte pattern repeated 10 times, with out_err=0.
REQ-041 Scenario 4: 'X' (0x58) at position 7 in otherwise 'G' characters -> out_err=1 and bits[65:64]=00; the next clean frame -> out_err=0.
REQ-042 Scenario 5: reset pulsed after 20 characters, then 40 x 'C' -> a single frame of repeated 01 symbols.
REQ-043 Scenario 6: flush after 15 characters concurrent with in_valid, then 40 x 'g' -> out_err=1 without DNA_LOWERCASE_EN and out_err=0 with it.
